// File: rtl/fnd_scan_ctrl.sv
// Stopwatch display stage: sequential double-dabble BCD conversion plus 4-digit FND scan (SSS.T).
// Optional leading-zero blanking when FND_LZ_BLANK_EN is defined.
module fnd_scan_ctrl #(
    parameter int SCAN_DIV = 100_000,
    parameter int CNT_W    = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    output logic             conv_busy,
    output logic [7:0]       fnd_data,
    output logic [3:0]       fnd_com
);

    localparam int BW = $clog2(CNT_W + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(9999);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } conv_state_t;

    conv_state_t state, state_next;

    logic [CNT_W-1:0] shift_reg;
    logic [CNT_W-1:0] last_val;
    logic [15:0]      bcd_acc;
    logic [15:0]      bcd_adj;
    logic [15:0]      disp_bcd;
    logic [BW-1:0]    bit_cnt;
    logic [3:0]       nib;
    logic             start_conv;
    logic             last_bit;

    logic [PW-1:0]    presc;
    logic             scan_tick;
    logic [1:0]       digit_idx;
    logic [3:0]       cur_digit;
    logic             blank;
    logic [6:0]       seg7;
    logic [7:0]       seg_next;

    assign start_conv = (state == IDLE) && (count != last_val);
    assign last_bit   = (bit_cnt == BW'(CNT_W - 1));
    assign conv_busy  = (state == SHIFT) || (state == LATCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_conv) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = '0;
        nib     = '0;
        for (int n = 0; n < 4; n++) begin
            nib = bcd_acc[4*n +: 4];
            bcd_adj[4*n +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            last_val  <= '0;
            bcd_acc   <= '0;
            bit_cnt   <= '0;
            disp_bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_conv) begin
                        shift_reg <= (count > MAX_VAL) ? MAX_VAL : count;
                        last_val  <= count;
                        bcd_acc   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    bcd_acc   <= (bcd_adj << 1) | 16'(shift_reg[CNT_W-1]);
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + BW'(1);
                end
                LATCH: begin
                    disp_bcd <= bcd_acc;
                end
                default: ;
            endcase
        end
    end

    assign scan_tick = (presc == PW'(SCAN_DIV - 1));
    assign cur_digit = disp_bcd[{digit_idx, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
`ifdef FND_LZ_BLANK_EN
        if (digit_idx == 2'd3 && disp_bcd[15:12] == 4'd0) blank = 1'b1;
        if (digit_idx == 2'd2 && disp_bcd[11:8] == 4'd0 && disp_bcd[15:12] == 4'd0) blank = 1'b1;
`endif
        case (cur_digit)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
        if (blank) seg7 = 7'h7F;
        // The dp stays lit on the seconds digit even if that digit is blanked.
        seg_next = {(digit_idx != 2'd1), seg7};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            digit_idx <= '0;
            fnd_com   <= 4'b1111;
            fnd_data  <= 8'hFF;
        end else begin
            presc <= scan_tick ? '0 : presc + PW'(1);
            if (scan_tick) begin
                fnd_com   <= ~(4'b0001 << digit_idx);
                fnd_data  <= seg_next;
                digit_idx <= digit_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl with SCAN_DIV=4; model derives digits with decimal arithmetic.
// Honours FND_LZ_BLANK_EN in its reference model.
module tb_fnd_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 14;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] count;
    logic             conv_busy;
    logic [7:0]       fnd_data;
    logic [3:0]       fnd_com;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fnd_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .conv_busy (conv_busy),
        .fnd_data  (fnd_data),
        .fnd_com   (fnd_com)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock edges since the last reset release drive the expected scan position.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [7:0] segOf(input int val, input int idx);
        int v;
        int dig;
        logic [7:0] s;
        logic blk;
        v = val;
        for (int i = 0; i < idx; i++) v = v / 10;
        dig = v % 10;
        blk = 1'b0;
`ifdef FND_LZ_BLANK_EN
        if (idx == 3 && val < 1000) blk = 1'b1;
        if (idx == 2 && val < 100)  blk = 1'b1;
`endif
        case (dig)
            0: s = 8'hC0;
            1: s = 8'hF9;
            2: s = 8'hA4;
            3: s = 8'hB0;
            4: s = 8'h99;
            5: s = 8'h92;
            6: s = 8'h82;
            7: s = 8'hF8;
            8: s = 8'h80;
            default: s = 8'h90;
        endcase
        if (blk) s = 8'hFF;
        if (idx == 1) s[7] = 1'b0;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int value, input int cycles);
        count = CNT_W'(value);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkScan(input int val);
        int idx;
        logic [3:0] exp_com;
        logic [7:0] exp_data;
        if (cyc < SCAN_DIV) begin
            exp_com  = 4'b1111;
            exp_data = 8'hFF;
        end else begin
            idx      = ((cyc / SCAN_DIV) - 1) % 4;
            exp_com  = ~(4'b0001 << idx);
            exp_data = segOf(val, idx);
        end
        checkOutput("fnd_com", 32'(fnd_com), 32'(exp_com));
        checkOutput("fnd_data", 32'(fnd_data), 32'(exp_data));
    endtask

    task automatic checkDisplay(input int val, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            checkScan(val);
        end
    endtask

    initial begin
        int v;
        int shown;
        reset = 1'b1;
        count = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(conv_busy), 32'd0);
        checkOutput("rst_com", 32'(fnd_com), 32'hF);
        checkOutput("rst_data", 32'(fnd_data), 32'hFF);

        $display("[TB] reset release with count=0");
        reset = 1'b0;
        checkDisplay(0, 24);

        $display("[TB] step to 1234");
        count = CNT_W'(1234);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            checkOutput("conv_busy", 32'(conv_busy), (n <= 15) ? 32'd1 : 32'd0);
        end
        repeat (4) @(negedge clk);
        checkDisplay(1234, 16);

        $display("[TB] wrap and clamp");
        applyStimulus(9999, 36);
        checkDisplay(9999, 16);
        applyStimulus(0, 36);
        checkDisplay(0, 16);
        applyStimulus(12000, 36);
        checkDisplay(9999, 16);
        applyStimulus(7, 36);
        checkDisplay(7, 16);
        applyStimulus(1000, 36);
        checkDisplay(1000, 16);

        $display("[TB] changes during conversion");
        for (int i = 0; i < 20; i++) applyStimulus(int'($urandom_range(0, 16383)), 1);
        applyStimulus(5678, 36);
        checkDisplay(5678, 16);

        $display("[TB] random values");
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 16383));
            shown = (v > 9999) ? 9999 : v;
            applyStimulus(v, 36);
            checkDisplay(shown, 16);
        end

        $display("[TB] reset mid-conversion");
        applyStimulus(0, 36);
        applyStimulus(4321, 5);
        checkOutput("busy_pre_rst", 32'(conv_busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(conv_busy), 32'd0);
        checkOutput("mid_rst_com", 32'(fnd_com), 32'hF);
        checkOutput("mid_rst_data", 32'(fnd_data), 32'hFF);
        @(negedge clk);
        reset = 1'b0;
        checkDisplay(0, 3);
        repeat (36) @(negedge clk);
        checkDisplay(4321, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
